mpsoc_sysid_checker: RTL and testbench
======================================

MPSOC_SYSID_CHECKER -- requirements
Module: mpsoc_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000, value expected from sysid word 0 (system ID).
REQ-002 Parameter EXPECTED_TS, default 32'h694E_7CE8, value expected from sysid word 1 (timestamp).
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535: per-word cycle budget before abort.
REQ-004 Parameter USE_RDV, default 0: 0 = data sampled on accept (read & !waitrequest); 1 = data sampled on avm_readdatavalid.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  single-cycle request to run one check sequence.
REQ-008 avm_address  out  1  Avalon-MM word address (0 = ID, 1 = timestamp).
REQ-009 avm_read  out  1  Avalon-MM read strobe.
REQ-010 avm_waitrequest  in  1  slave stall; tie 0 for zero-wait slaves.
REQ-011 avm_readdata  in  32  slave read data.
REQ-012 avm_readdatavalid  in  1  read data valid; used only when USE_RDV=1.
REQ-013 busy  out  1  high from the cycle after start is accepted until done.
REQ-014 done  out  1  one-cycle pulse at sequence end.
REQ-015 id_ok, ts_ok, timeout  out  1 each  sticky result flags, valid from done until next accepted start.
REQ-016 id_value, ts_value  out  32 each  captured words, held until next accepted start.

Function
REQ-017 States: IDLE, REQ_ID, RSP_ID, REQ_TS, RSP_TS, FIN; FIN lasts exactly one cycle and drives done=1.
REQ-018 IDLE: start=1 moves to REQ_ID and clears id_ok, ts_ok, timeout, id_value, ts_value in the same edge.
REQ-019 REQ_x: avm_read=1, avm_address per word; address and read held stable while avm_waitrequest=1.
REQ-020 USE_RDV=0: on read & !waitrequest, capture readdata, evaluate compare, skip RSP_x (REQ_ID->REQ_TS, REQ_TS->FIN); one word per cycle minimum with a zero-wait slave.
REQ-021 USE_RDV=1: accept moves REQ_x->RSP_x with avm_read=0; first readdatavalid in RSP_x captures data; readdatavalid in any other state is ignored.
REQ-022 Compare: id_ok = (captured word 0 == EXPECTED_ID), ts_ok = (captured word 1 == EXPECTED_TS), full 32-bit equality.
REQ-023 Timeout counter (16 bit) cleared on entry to each REQ_x, increments every cycle in REQ_x/RSP_x; reaching TIMEOUT_CYCLES without capture sets timeout=1, deasserts avm_read, goes to FIN, leaves remaining ok flags 0.
REQ-024 Capture in the same cycle the counter reaches TIMEOUT_CYCLES wins; no timeout.
REQ-025 start while busy or in FIN is ignored; no queuing.
REQ-026 Best case USE_RDV=0, waitrequest=0: start at cycle 0 -> done at cycle 3.

Reset
REQ-027 Asynchronous reset forces IDLE, avm_read=0, avm_address=0, busy=0, done=0, all flags 0, id_value=ts_value=0, counter=0.
REQ-028 Reset mid-transfer drops avm_read immediately; a late readdatavalid after release is ignored (state IDLE).

Structure
REQ-029 Shared package holds state enum, COUNTER_W=16 and word-address constants ADDR_ID=0, ADDR_TS=1.
REQ-030 One sub-module mpsoc_timeout_counter (clear, enable, limit -> expired); all else in top.

Verification
REQ-031 Zero-wait slave returning 0 / 32'h694E7CE8, USE_RDV=0 -> done at cycle 3, id_ok=1, ts_ok=1, timeout=0.
REQ-032 waitrequest held 4 cycles per word -> avm_address/avm_read stable throughout, done at cycle 11, both ok.
REQ-033 Slave returns ID 32'h1 -> id_ok=0, ts_ok=1, id_value=32'h1.
REQ-034 USE_RDV=1, TIMEOUT_CYCLES=8, readdatavalid never asserted -> timeout=1, id_ok=ts_ok=0, done 8 cycles after REQ_ID entry.
REQ-035 start pulsed while busy, then reset asserted during RSP_TS -> second start ignored; reset yields all outputs 0, stray readdatavalid after release has no effect.

Source files
------------

// File: rtl/mpsoc_sysid_checker_pkg.sv
// Shared types and constants for the sysid checker and its timeout counter.
package mpsoc_sysid_checker_pkg;

    localparam int COUNTER_W = 16;

    // Avalon-MM word addresses inside the sysid slave.
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_ID = 3'd1,
        ST_RSP_ID = 3'd2,
        ST_REQ_TS = 3'd3,
        ST_RSP_TS = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

endpackage

// File: rtl/mpsoc_timeout_counter.sv
// Per-word cycle budget. o_expired is high in the cycle whose clock edge
// would bring the count up to i_limit, so the owner can abort on that edge.
module mpsoc_timeout_counter
    import mpsoc_sysid_checker_pkg::*;
(
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_enable,
    input  logic [COUNTER_W-1:0] i_limit,
    output logic                 o_expired
);

    logic [COUNTER_W-1:0] r_count;
    logic [COUNTER_W-1:0] w_last;

    assign w_last    = i_limit - COUNTER_W'(1);
    assign o_expired = i_enable && (r_count == w_last);

    // Count cycles while enabled; clear has priority so each word starts at 0.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + COUNTER_W'(1);
        end
    end

endmodule

// File: rtl/mpsoc_sysid_checker.sv
// Reads the ID and timestamp words from an Avalon-MM sysid slave and checks
// them against build-time expectations.
// Handshake: a read is accepted in the cycle where o_avm_read=1 and
// i_avm_waitrequest=0; address/read are held unchanged while stalled. With
// USE_RDV=1 data is taken from the first i_avm_readdatavalid after accept.
module mpsoc_sysid_checker
    import mpsoc_sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'h694E_7CE8,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          USE_RDV        = 1'b0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    output logic        o_avm_address,
    output logic        o_avm_read,
    input  logic        i_avm_waitrequest,
    input  logic [31:0] i_avm_readdata,
    input  logic        i_avm_readdatavalid,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_id_ok,
    output logic        o_ts_ok,
    output logic        o_timeout,
    output logic [31:0] o_id_value,
    output logic [31:0] o_ts_value,
    output logic [2:0]  o_dbg_state
);

    localparam logic [COUNTER_W-1:0] LIMIT = COUNTER_W'(TIMEOUT_CYCLES);

    state_e      r_state;
    state_e      w_next;
    logic        w_cnt_clear;
    logic        w_cnt_en;
    logic        w_expired;
    logic        w_cap_id;
    logic        w_cap_ts;
    logic        w_to_hit;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    mpsoc_timeout_counter u_timeout (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (w_cnt_clear),
        .i_enable  (w_cnt_en),
        .i_limit   (LIMIT),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, bus strobes and capture/timeout events. A capture always
    // beats an expiring budget in the same cycle.
    always_comb begin
        w_next        = r_state;
        w_cnt_clear   = 1'b0;
        w_cnt_en      = 1'b0;
        w_cap_id      = 1'b0;
        w_cap_ts      = 1'b0;
        w_to_hit      = 1'b0;
        o_avm_read    = 1'b0;
        o_avm_address = ADDR_ID;
        o_busy        = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_next      = ST_REQ_ID;
                    w_cnt_clear = 1'b1;
                end
            end
            ST_REQ_ID: begin
                o_avm_read = 1'b1;
                o_busy     = 1'b1;
                w_cnt_en   = 1'b1;
                if (!i_avm_waitrequest && !USE_RDV) begin
                    w_cap_id    = 1'b1;
                    w_next      = ST_REQ_TS;
                    w_cnt_clear = 1'b1;
                end else if (w_expired) begin
                    w_to_hit = 1'b1;
                    w_next   = ST_FIN;
                end else if (!i_avm_waitrequest) begin
                    w_next = ST_RSP_ID;
                end
            end
            ST_RSP_ID: begin
                o_busy   = 1'b1;
                w_cnt_en = 1'b1;
                if (i_avm_readdatavalid) begin
                    w_cap_id    = 1'b1;
                    w_next      = ST_REQ_TS;
                    w_cnt_clear = 1'b1;
                end else if (w_expired) begin
                    w_to_hit = 1'b1;
                    w_next   = ST_FIN;
                end
            end
            ST_REQ_TS: begin
                o_avm_read    = 1'b1;
                o_avm_address = ADDR_TS;
                o_busy        = 1'b1;
                w_cnt_en      = 1'b1;
                if (!i_avm_waitrequest && !USE_RDV) begin
                    w_cap_ts = 1'b1;
                    w_next   = ST_FIN;
                end else if (w_expired) begin
                    w_to_hit = 1'b1;
                    w_next   = ST_FIN;
                end else if (!i_avm_waitrequest) begin
                    w_next = ST_RSP_TS;
                end
            end
            ST_RSP_TS: begin
                o_avm_address = ADDR_TS;
                o_busy        = 1'b1;
                w_cnt_en      = 1'b1;
                if (i_avm_readdatavalid) begin
                    w_cap_ts = 1'b1;
                    w_next   = ST_FIN;
                end else if (w_expired) begin
                    w_to_hit = 1'b1;
                    w_next   = ST_FIN;
                end
            end
            ST_FIN: begin
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Result flags and captured words: cleared by an accepted start, then
    // updated by captures and a timeout; held otherwise.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
        end else begin
            if (r_state == ST_IDLE && i_start) begin
                r_id_ok    <= 1'b0;
                r_ts_ok    <= 1'b0;
                r_timeout  <= 1'b0;
                r_id_value <= '0;
                r_ts_value <= '0;
            end
            if (w_cap_id) begin
                r_id_value <= i_avm_readdata;
                r_id_ok    <= (i_avm_readdata == EXPECTED_ID);
            end
            if (w_cap_ts) begin
                r_ts_value <= i_avm_readdata;
                r_ts_ok    <= (i_avm_readdata == EXPECTED_TS);
            end
            if (w_to_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_id_ok     = r_id_ok;
    assign o_ts_ok     = r_ts_ok;
    assign o_timeout   = r_timeout;
    assign o_id_value  = r_id_value;
    assign o_ts_value  = r_ts_value;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mpsoc_sysid_checker.sv
// Bench for mpsoc_sysid_checker: instance A (accept sampling, waitstate
// slave) and instance B (readdatavalid sampling, 8-cycle budget).
module tb_mpsoc_sysid_checker;

    localparam logic [31:0] TS_GOOD = 32'h694E_7CE8;
    localparam logic [31:0] ID_A    = 32'h0000_0000;
    localparam logic [31:0] ID_B    = 32'hCAFE_0001;

    logic clk;
    int   checks = 0;
    int   errors = 0;
    logic [66:0] exp_q[$];

    // ---------------- instance A ----------------
    logic        a_reset, a_start, a_address, a_read, a_waitrequest;
    logic [31:0] a_readdata, a_id_value, a_ts_value, a_id_word, a_ts_word;
    logic        a_busy, a_done, a_id_ok, a_ts_ok, a_timeout;
    logic [2:0]  a_state;
    int          a_stall_n, a_stall_cnt;

    mpsoc_sysid_checker u_a (
        .i_clock(clk), .i_reset(a_reset), .i_start(a_start),
        .o_avm_address(a_address), .o_avm_read(a_read),
        .i_avm_waitrequest(a_waitrequest), .i_avm_readdata(a_readdata),
        .i_avm_readdatavalid(1'b0),
        .o_busy(a_busy), .o_done(a_done), .o_id_ok(a_id_ok), .o_ts_ok(a_ts_ok),
        .o_timeout(a_timeout), .o_id_value(a_id_value), .o_ts_value(a_ts_value),
        .o_dbg_state(a_state)
    );

    // ---------------- instance B ----------------
    logic        b_reset, b_start, b_address, b_read, b_rdv;
    logic [31:0] b_readdata, b_id_value, b_ts_value;
    logic        b_busy, b_done, b_id_ok, b_ts_ok, b_timeout;
    logic [2:0]  b_state;

    mpsoc_sysid_checker #(
        .EXPECTED_ID(ID_B), .EXPECTED_TS(TS_GOOD), .TIMEOUT_CYCLES(8), .USE_RDV(1'b1)
    ) u_b (
        .i_clock(clk), .i_reset(b_reset), .i_start(b_start),
        .o_avm_address(b_address), .o_avm_read(b_read),
        .i_avm_waitrequest(1'b0), .i_avm_readdata(b_readdata),
        .i_avm_readdatavalid(b_rdv),
        .o_busy(b_busy), .o_done(b_done), .o_id_ok(b_id_ok), .o_ts_ok(b_ts_ok),
        .o_timeout(b_timeout), .o_id_value(b_id_value), .o_ts_value(b_ts_value),
        .o_dbg_state(b_state)
    );

    logic [73:0] a_all, b_all;
    assign a_all = {a_read, a_address, a_busy, a_done, a_id_ok, a_ts_ok, a_timeout,
                    a_id_value, a_ts_value, a_state};
    assign b_all = {b_read, b_address, b_busy, b_done, b_id_ok, b_ts_ok, b_timeout,
                    b_id_value, b_ts_value, b_state};

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- slave model for A ----------------
    // Stalls each read for a_stall_n cycles, then accepts.
    assign a_waitrequest = a_read && (a_stall_cnt < a_stall_n);
    assign a_readdata    = a_address ? a_ts_word : a_id_word;

    always @(posedge clk) begin
        if (!a_read || !a_waitrequest) a_stall_cnt <= 0;
        else                           a_stall_cnt <= a_stall_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [66:0] model(input logic [31:0] id, input logic [31:0] ts,
                                          input logic [31:0] exp_id, input logic to);
        if (to) return {1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        return {1'b0, ts == TS_GOOD, id == exp_id, id, ts};
    endfunction

    task automatic pop_compare(input string tag, input logic [66:0] obs);
        logic [66:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed result %0h expected queue entry none", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // One check sequence on A; cycle 0 is the start cycle.
    task automatic run_a(input string tag, input logic [31:0] id, input logic [31:0] ts,
                         input int stall, input bit poke_fin);
        int cyc;
        a_id_word = id;
        a_ts_word = ts;
        a_stall_n = stall;
        exp_q.push_back(model(id, ts, ID_A, 1'b0));
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        cyc = 1;
        while (a_done !== 1'b1 && cyc < 40) begin
            // {read, address, busy}: ID word until its accept, then TS word
            check({tag, "_bus"}, {a_read, a_address, a_busy},
                  (cyc <= stall + 1) ? 3'b101 : 3'b111);
            tick();
            cyc++;
        end
        check({tag, "_done"}, a_done, 1'b1);
        check({tag, "_done_cycle"}, cyc, 2 * stall + 3);
        check({tag, "_fin_bus"}, {a_read, a_busy}, 2'b00);
        pop_compare({tag, "_result"}, {a_timeout, a_ts_ok, a_id_ok, a_id_value, a_ts_value});
        if (poke_fin) a_start = 1'b1;
        tick();
        a_start = 1'b0;
        check({tag, "_after_fin"}, {a_done, a_busy, a_state}, 5'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        a_reset = 1'b1; a_start = 1'b0; a_stall_n = 0;
        a_id_word = '0; a_ts_word = '0;
        b_reset = 1'b1; b_start = 1'b0; b_rdv = 1'b0; b_readdata = '0;
        tick();
        tick();
        check("a_reset_outs", a_all, 74'h0);
        check("b_reset_outs", b_all, 74'h0);
        a_reset = 1'b0;
        b_reset = 1'b0;
        tick();

        // A: zero-wait slave, start poked during FIN is ignored
        run_a("a_zero_wait", ID_A, TS_GOOD, 0, 1'b1);
        tick();
        check("a_fin_start_ignored", {a_busy, a_state}, 4'b0);
        // A: four waitstates per word
        run_a("a_wait4", ID_A, TS_GOOD, 4, 1'b0);
        // A: wrong ID
        run_a("a_bad_id", 32'h0000_0001, TS_GOOD, 0, 1'b0);
        // A: timestamp off by one bit
        run_a("a_bad_ts", ID_A, 32'h694E_7CE9, 2, 1'b0);
        // A: both words wrong
        run_a("a_both_bad", 32'hFFFF_FFFF, 32'h0, 1, 1'b0);

        // B: normal readdatavalid flow, stray rdv in REQ_TS ignored
        exp_q.push_back(model(ID_B, TS_GOOD, ID_B, 1'b0));
        b_start = 1'b1;
        tick();                                   // cycle 1: REQ_ID
        b_start = 1'b0;
        check("b_req_id", {b_read, b_address, b_state}, {2'b10, 3'd1});
        tick();                                   // cycle 2: RSP_ID
        check("b_rsp_id", {b_read, b_busy, b_state}, {2'b01, 3'd2});
        b_rdv = 1'b1; b_readdata = ID_B;
        tick();                                   // cycle 3: REQ_TS
        b_readdata = 32'hDEAD_BEEF;
        check("b_req_ts", {b_read, b_address, b_state}, {2'b11, 3'd3});
        tick();                                   // cycle 4: RSP_TS
        check("b_stray_rdv", b_id_value, ID_B);
        b_readdata = TS_GOOD;
        tick();                                   // cycle 5: FIN
        b_rdv = 1'b0;
        check("b_rdv_done", b_done, 1'b1);
        pop_compare("b_rdv_result", {b_timeout, b_ts_ok, b_id_ok, b_id_value, b_ts_value});
        tick();

        // B: readdatavalid never arrives -> timeout 8 cycles after REQ_ID entry
        exp_q.push_back(model(32'h0, 32'h0, ID_B, 1'b1));
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        cyc = 1;
        while (b_done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("b_to_done", b_done, 1'b1);
        check("b_to_cycle", cyc, 9);
        check("b_to_read", b_read, 1'b0);
        pop_compare("b_to_result", {b_timeout, b_ts_ok, b_id_ok, b_id_value, b_ts_value});
        tick();

        // B: capture in the last budget cycle wins over the timeout
        exp_q.push_back(model(ID_B, TS_GOOD, ID_B, 1'b0));
        b_start = 1'b1;
        tick();                                   // cycle 1
        b_start = 1'b0;
        repeat (7) tick();                        // cycle 8, still RSP_ID
        check("b_edge_waiting", b_state, 3'd2);
        b_rdv = 1'b1; b_readdata = ID_B;
        tick();                                   // cycle 9
        b_rdv = 1'b0;
        check("b_edge_captured", {b_timeout, b_state}, {1'b0, 3'd3});
        tick();                                   // cycle 10: RSP_TS
        b_rdv = 1'b1; b_readdata = TS_GOOD;
        tick();                                   // cycle 11: FIN
        b_rdv = 1'b0;
        check("b_edge_done", b_done, 1'b1);
        pop_compare("b_edge_result", {b_timeout, b_ts_ok, b_id_ok, b_id_value, b_ts_value});
        tick();

        // B: start while busy ignored, then reset during RSP_TS
        b_start = 1'b1;
        tick();                                   // cycle 1: REQ_ID
        b_start = 1'b0;
        tick();                                   // cycle 2: RSP_ID
        b_start = 1'b1;
        b_rdv = 1'b1; b_readdata = ID_B;
        tick();                                   // cycle 3: REQ_TS
        b_start = 1'b0;
        b_rdv = 1'b0;
        check("b_busy_start_ignored", {b_id_ok, b_id_value, b_state}, {1'b1, ID_B, 3'd3});
        tick();                                   // cycle 4: RSP_TS
        check("b_in_rsp_ts", {b_busy, b_state}, {1'b1, 3'd4});
        #2 b_reset = 1'b1;
        #1 check("b_async_reset", b_all, 74'h0);
        tick();
        b_reset = 1'b0;
        b_rdv = 1'b1; b_readdata = TS_GOOD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("b_late_rdv", b_all, 74'h0);
        end
        b_rdv = 1'b0;

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound in case the sequence stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule
